inst_fetch_bridge: RTL and testbench

- Sits between the core's instruction-ROM port (rom_ce_o / rom_addr_o / rom_data_i) and a request/grant/response memory bus with variable latency.
- Holds one fetched word in a single-entry fetch buffer.
- While a fetch is outstanding, asserts a stall request to ctrl so PC, IF/ID and everything upstream hold.
- On a buffer hit, returns the instruction in the same cycle with no stall.

---
 rtl/inst_fetch_bridge.sv | 100 ++++++++++
 tb/tb_inst_fetch_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: adapts the core's single-cycle ROM port to a
// request/grant/response bus. It keeps a one-word fetch buffer and stalls the core on a miss.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_INST       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        buf_valid;
  logic [29:0] buf_addr;
  logic [31:0] buf_data;
  logic [29:0] req_addr;
  logic [15:0] tmo_cnt;
  logic        discard;
  logic        hit;
  logic        unused_ok;

  // Byte-offset bits never take part in the word compare.
  assign unused_ok = &{1'b0, cpu_addr_i[1:0]};

  assign hit        = cpu_ce_i & buf_valid & (cpu_addr_i[31:2] == buf_addr);
  assign cpu_data_o = (rst && hit) ? buf_data : '0;
  assign stallreq_o = rst & cpu_ce_i & (~hit | (state != IDLE));
  assign bus_addr_o = {req_addr, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      req_addr  <= '0;
      tmo_cnt   <= '0;
      discard   <= 1'b0;
      bus_req_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (flush_i) buf_valid <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (cpu_ce_i && !hit && !flush_i) begin
            req_addr  <= cpu_addr_i[31:2];
            bus_req_o <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (flush_i) discard <= 1'b1;
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            tmo_cnt   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (flush_i) discard <= 1'b1;
          if (bus_rvalid_i || tmo_cnt == TMO_LAST) begin
            state   <= IDLE;
            discard <= 1'b0;
            // A flush now or earlier in this transaction drops the result, error included.
            if (!discard && !flush_i) begin
              buf_valid <= 1'b1;
              buf_addr  <= req_addr;
              if (bus_rvalid_i && !bus_err_i) begin
                buf_data <= bus_rdata_i;
              end else begin
                buf_data <= ERR_INST;
                err_o    <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge (TIMEOUT_CYCLES=8).
module tb_inst_fetch_bridge;

  localparam logic [31:0] ERR = 32'hBAD0_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        stallreq;
  logic        flush;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.TIMEOUT_CYCLES(8), .ERR_INST(ERR)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce), .cpu_addr_i(cpu_addr),
    .cpu_data_o(cpu_data), .stallreq_o(stallreq), .flush_i(flush),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_gnt_i(bus_gnt),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err),
    .err_o(err)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cpu_ce = 1'b1; cpu_addr = 32'h100; flush = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF; bus_err = 1'b0;
    next_cycle; next_cycle;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stallreq); end
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", cpu_data); end
    next_cycle;
    rst = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_miss;
    int stalls = 0;
    @(negedge clk);
    if (stallreq) stalls++;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL miss_idle_req: got %b want 0", bus_req); end
    next_cycle;
    bus_gnt = 1'b1;
    @(negedge clk);
    if (stallreq) stalls++;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL miss_req: got %b want 1", bus_req); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL miss_addr: got %h want 00000100", bus_addr); end
    next_cycle;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h3401_0020;
    @(negedge clk);
    if (stallreq) stalls++;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop: got %b want 0", bus_req); end
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    if (stallreq) stalls++;
    checks++; if (stalls != 3) begin errors++; $display("FAIL miss_stall_cycles: got %0d want 3", stalls); end
    checks++; if (cpu_data !== 32'h3401_0020) begin errors++; $display("FAIL miss_data: got %h want 34010020", cpu_data); end
    next_cycle;
  endtask

  task automatic test_hit;
    cpu_addr = 32'h103;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b want 0", stallreq); end
    checks++; if (cpu_data !== 32'h3401_0020) begin errors++; $display("FAIL hit_data: got %h want 34010020", cpu_data); end
    next_cycle;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL hit_no_req: got %b want 0", bus_req); end
    cpu_ce = 1'b0; cpu_addr = 32'h900;
    #1;
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL ce_off_stall: got %b want 0", stallreq); end
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL ce_off_data: got %h want 0", cpu_data); end
    next_cycle;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ce_off_no_req: got %b want 0", bus_req); end
    next_cycle;
    cpu_ce = 1'b1;
  endtask

  task automatic test_gnt_delay;
    int accepted = 0;
    cpu_addr = 32'h200;
    next_cycle;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_req && bus_gnt) accepted++;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL hold_req[%0d]: got %b want 1", i, bus_req); end
      checks++; if (bus_addr !== 32'h200) begin errors++; $display("FAIL hold_addr[%0d]: got %h want 00000200", i, bus_addr); end
      next_cycle;
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    if (bus_req && bus_gnt) accepted++;
    next_cycle;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    if (bus_req && bus_gnt) accepted++;
    next_cycle;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (accepted != 1) begin errors++; $display("FAIL hold_accepted: got %0d want 1", accepted); end
    checks++; if (cpu_data !== 32'h1111_2222) begin errors++; $display("FAIL hold_data: got %h want 11112222", cpu_data); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL hold_stall: got %b want 0", stallreq); end
    next_cycle;
  endtask

  task automatic test_timeout;
    cpu_addr = 32'h300;
    next_cycle;
    bus_gnt = 1'b1;
    next_cycle;
    bus_gnt = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (err !== 1'b0 || stallreq !== 1'b1) begin errors++; $display("FAIL tmo_wait[%0d]: got err=%b stall=%b want err=0 stall=1", i, err, stallreq); end
      next_cycle;
    end
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err); end
    checks++; if (cpu_data !== ERR) begin errors++; $display("FAIL tmo_data: got %h want %h", cpu_data, ERR); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL tmo_stall: got %b want 0", stallreq); end
    next_cycle;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse: got %b want 0", err); end
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (cpu_data !== ERR) begin errors++; $display("FAIL stray_rvalid: got %h want %h", cpu_data, ERR); end
    next_cycle;
  endtask

  task automatic test_bus_err;
    cpu_addr = 32'h400;
    next_cycle;
    bus_gnt = 1'b1;
    next_cycle;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL berr_early: got %b want 0", err); end
    next_cycle;
    bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL berr_err: got %b want 1", err); end
    checks++; if (cpu_data !== ERR) begin errors++; $display("FAIL berr_data: got %h want %h", cpu_data, ERR); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL berr_stall: got %b want 0", stallreq); end
    next_cycle;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL berr_pulse: got %b want 0", err); end
    next_cycle;
  endtask

  task automatic test_flush;
    cpu_addr = 32'h500;
    next_cycle;
    bus_gnt = 1'b1;
    next_cycle;
    bus_gnt = 1'b0; flush = 1'b1;
    next_cycle;
    flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL flush_wait_data: got %h want 0", cpu_data); end
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL flush_data: got %h want 0", cpu_data); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", stallreq); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", err); end
    next_cycle;
    bus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h500) begin errors++; $display("FAIL flush_refetch: got req=%b addr=%h want req=1 addr=00000500", bus_req, bus_addr); end
    checks++; if (cpu_data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL flush_late: got data=%h err=%b want data=0 err=0", cpu_data, err); end
    next_cycle;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0500_AAAA;
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (cpu_data !== 32'h0500_AAAA || stallreq !== 1'b0) begin errors++; $display("FAIL flush_refill: got data=%h stall=%b want 0500aaaa 0", cpu_data, stallreq); end
    next_cycle;
  endtask

  task automatic test_reset_midwait;
    cpu_addr = 32'h600;
    next_cycle;
    bus_gnt = 1'b1;
    next_cycle;
    bus_gnt = 1'b0;
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    next_cycle;
    bus_rvalid = 1'b1; bus_rdata = 32'h6666_0000;
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (cpu_data !== 32'h6666_0000 || stallreq !== 1'b0) begin errors++; $display("FAIL rst_glitch: got data=%h stall=%b want 66660000 0", cpu_data, stallreq); end
    next_cycle;
    cpu_addr = 32'h700;
    next_cycle;
    bus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstw_req: got %b want 1", bus_req); end
    next_cycle;
    bus_gnt = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0 || cpu_data !== 32'h0) begin errors++; $display("FAIL rstw_low: got stall=%b data=%h want 0 0", stallreq, cpu_data); end
    next_cycle;
    rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h7777_0000; cpu_addr = 32'h600;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstw_req_low: got %b want 0", bus_req); end
    checks++; if (stallreq !== 1'b1 || cpu_data !== 32'h0) begin errors++; $display("FAIL rstw_buf_inval: got stall=%b data=%h want 1 0", stallreq, cpu_data); end
    next_cycle;
    bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h600) begin errors++; $display("FAIL rstw_refetch: got req=%b addr=%h want 1 00000600", bus_req, bus_addr); end
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL rstw_late_rvalid: got %h want 0", cpu_data); end
    next_cycle;
    cpu_ce = 1'b0;
  endtask

  initial begin
    test_reset;
    test_miss;
    test_hit;
    test_gnt_delay;
    test_timeout;
    test_bus_err;
    test_flush;
    test_reset_midwait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
